// File: rtl/pipeline_event_monitor.sv
// rtl/pipeline_event_monitor.sv - pipeline stall/clear/memory event counters with halt and watchdog detection
module pipeline_event_monitor #(
    parameter int NUM_STAGES  = 5,
    parameter int NUM_PORTS   = 2,
    parameter int CNT_WIDTH   = 32,
    parameter int HALT_CYCLES = 4,
    parameter int TIMEOUT     = 1024,
    parameter int SEL_WIDTH   = 5,
    localparam int TPW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_STAGES-1:0] stall,
    input  logic [NUM_STAGES-1:0] clear,
    input  logic [31:0]           id_ir,
    input  logic                  id_valid,
    input  logic [NUM_PORTS-1:0]  mem_read,
    input  logic [NUM_PORTS-1:0]  mem_write,
    input  logic [NUM_PORTS-1:0]  mem_resp,
    input  logic                  cnt_clr,
    input  logic [SEL_WIDTH-1:0]  rd_sel,
    output logic [CNT_WIDTH-1:0]  rd_data,
    output logic                  halt,
    output logic                  timeout,
    output logic [TPW-1:0]        timeout_port
);

    // Counter index layout: cycle, stalls, clears, per-port completed transactions.
    localparam int NUM_CNT  = 1 + 2 * NUM_STAGES + NUM_PORTS;
    localparam int STALL_B  = 1;
    localparam int CLEAR_B  = 1 + NUM_STAGES;
    localparam int TRANS_B  = 1 + 2 * NUM_STAGES;
    localparam int RUN_W    = 8;
    localparam int WD_W     = 16;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [RUN_W-1:0]     HALT_LIM = RUN_W'(HALT_CYCLES);
    localparam logic [WD_W-1:0]      WD_MAX   = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0]      WD_FIRE  = WD_W'(TIMEOUT - 2);

    // RISC-V "beq x0,x0,0" and "jal x0,0": the branch-to-self halt idiom.
    localparam logic [31:0] HALT_BEQ = 32'h0000_0063;
    localparam logic [31:0] HALT_JAL = 32'h0000_006F;

    logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
    logic [CNT_WIDTH-1:0] cnt_d [NUM_CNT];
    logic [NUM_CNT-1:0]   evt;
    logic [CNT_WIDTH-1:0] rd_q, rd_d;

    logic [RUN_W-1:0]     run_q, run_d;
    logic [RUN_W-1:0]     run_inc;
    logic                 halt_q, halt_d;
    logic                 match;

    logic [WD_W-1:0]      wd_q [NUM_PORTS];
    logic [WD_W-1:0]      wd_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] outstanding;
    logic [NUM_PORTS-1:0] fire;
    logic                 timeout_q, timeout_d;
    logic [TPW-1:0]       tport_q, tport_d;

    // Event strobes feeding each counter in index order.
    always_comb begin
        evt    = '0;
        evt[0] = 1'b1;
        for (int i = 0; i < NUM_STAGES; i++) begin
            evt[STALL_B + i] = stall[i];
            evt[CLEAR_B + i] = clear[i];
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            evt[TRANS_B + p] = (mem_read[p] | mem_write[p]) & mem_resp[p];
        end
    end

    // Saturating increment, frozen once halt has been seen.
    always_comb begin
        for (int k = 0; k < NUM_CNT; k++) begin
            cnt_d[k] = cnt_q[k];
            if (!halt_q && evt[k] && (cnt_q[k] != CNT_MAX)) begin
                cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
            end
        end
    end

    // Readout mux; indices beyond the map read zero.
    always_comb begin
        rd_d = '0;
        for (int k = 0; k < NUM_CNT; k++) begin
            if (rd_sel == SEL_WIDTH'(k)) begin
                rd_d = cnt_q[k];
            end
        end
    end

    // Halt run-length tracking; the run counter parks at the limit to stay in range.
    always_comb begin
        match   = id_valid & ((id_ir == HALT_BEQ) | (id_ir == HALT_JAL));
        run_inc = run_q + RUN_W'(1);
        run_d   = '0;
        if (match) begin
            run_d = (run_q == HALT_LIM) ? run_q : run_inc;
        end
        halt_d = halt_q | (match & (run_inc == HALT_LIM));
    end

    // Per-port watchdogs; first firing latches the lowest-index port.
    always_comb begin
        timeout_d = timeout_q;
        tport_d   = tport_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            outstanding[p] = (mem_read[p] | mem_write[p]) & ~mem_resp[p];
            fire[p]        = outstanding[p] & (wd_q[p] == WD_FIRE);
            wd_d[p]        = '0;
            if (outstanding[p]) begin
                wd_d[p] = (wd_q[p] == WD_MAX) ? wd_q[p] : wd_q[p] + WD_W'(1);
            end
        end
        if (!timeout_q && (|fire)) begin
            timeout_d = 1'b1;
            for (int p = NUM_PORTS - 1; p >= 0; p--) begin
                if (fire[p]) begin
                    tport_d = TPW'(p);
                end
            end
        end
    end

    // State registers; cnt_clr wipes everything except the readout register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CNT; k++) cnt_q[k] <= '0;
            for (int p = 0; p < NUM_PORTS; p++) wd_q[p] <= '0;
            rd_q      <= '0;
            run_q     <= '0;
            halt_q    <= 1'b0;
            timeout_q <= 1'b0;
            tport_q   <= '0;
        end else begin
            rd_q <= rd_d;
            if (cnt_clr) begin
                for (int k = 0; k < NUM_CNT; k++) cnt_q[k] <= '0;
                for (int p = 0; p < NUM_PORTS; p++) wd_q[p] <= '0;
                run_q     <= '0;
                halt_q    <= 1'b0;
                timeout_q <= 1'b0;
                tport_q   <= '0;
            end else begin
                for (int k = 0; k < NUM_CNT; k++) cnt_q[k] <= cnt_d[k];
                for (int p = 0; p < NUM_PORTS; p++) wd_q[p] <= wd_d[p];
                run_q     <= run_d;
                halt_q    <= halt_d;
                timeout_q <= timeout_d;
                tport_q   <= tport_d;
            end
        end
    end

    assign rd_data      = rd_q;
    assign halt         = halt_q;
    assign timeout      = timeout_q;
    assign timeout_port = tport_q;

endmodule

// File: tb/tb_pipeline_event_monitor.sv
// tb/tb_pipeline_event_monitor.sv - randomized and directed checks of pipeline_event_monitor against a reference model
module tb_pipeline_event_monitor;

    localparam int NS   = 5;
    localparam int NP   = 2;
    localparam int NCNT = 1 + 2 * NS + NP;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NS-1:0] stall;
    logic [NS-1:0] clear;
    logic [31:0]   id_ir;
    logic          id_valid;
    logic [NP-1:0] mem_read;
    logic [NP-1:0] mem_write;
    logic [NP-1:0] mem_resp;
    logic          cnt_clr;
    logic [4:0]    rd_sel;

    logic [31:0]   a_rd;
    logic          a_halt, a_tmo, a_tport;
    logic [3:0]    b_rd;
    logic          b_halt, b_tmo, b_tport;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    pipeline_event_monitor #(
        .NUM_STAGES(NS), .NUM_PORTS(NP), .CNT_WIDTH(32),
        .HALT_CYCLES(4), .TIMEOUT(1024), .SEL_WIDTH(5)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .stall(stall), .clear(clear),
        .id_ir(id_ir), .id_valid(id_valid), .mem_read(mem_read),
        .mem_write(mem_write), .mem_resp(mem_resp), .cnt_clr(cnt_clr),
        .rd_sel(rd_sel), .rd_data(a_rd), .halt(a_halt),
        .timeout(a_tmo), .timeout_port(a_tport)
    );

    pipeline_event_monitor #(
        .NUM_STAGES(NS), .NUM_PORTS(NP), .CNT_WIDTH(4),
        .HALT_CYCLES(1), .TIMEOUT(8), .SEL_WIDTH(5)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .stall(stall), .clear(clear),
        .id_ir(id_ir), .id_valid(id_valid), .mem_read(mem_read),
        .mem_write(mem_write), .mem_resp(mem_resp), .cnt_clr(cnt_clr),
        .rd_sel(rd_sel), .rd_data(b_rd), .halt(b_halt),
        .timeout(b_tmo), .timeout_port(b_tport)
    );

    // Reference model state, one slot per DUT configuration.
    longint m_cnt   [2][NCNT];
    longint m_rd    [2];
    int     m_run   [2];
    bit     m_halt  [2];
    bit     m_tmo   [2];
    int     m_tport [2];
    int     m_age   [2][NP];
    longint c_max   [2] = '{64'hFFFF_FFFF, 64'hF};
    int     c_hc    [2] = '{4, 1};
    int     c_to    [2] = '{1024, 8};

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock of behaviour from the counter map and event rules, applied to current inputs.
    task automatic model_step(input int c);
        longint old [NCNT];
        bit     ev  [NCNT];
        int     first;
        bit     is_halt_instr;
        for (int k = 0; k < NCNT; k++) old[k] = m_cnt[c][k];
        if (!rst_n) begin
            for (int k = 0; k < NCNT; k++) m_cnt[c][k] = 0;
            for (int p = 0; p < NP; p++) m_age[c][p] = 0;
            m_rd[c] = 0; m_run[c] = 0; m_halt[c] = 0; m_tmo[c] = 0; m_tport[c] = 0;
            return;
        end
        m_rd[c] = (int'(rd_sel) < NCNT) ? old[rd_sel] : 0;
        if (cnt_clr) begin
            for (int k = 0; k < NCNT; k++) m_cnt[c][k] = 0;
            for (int p = 0; p < NP; p++) m_age[c][p] = 0;
            m_run[c] = 0; m_halt[c] = 0; m_tmo[c] = 0; m_tport[c] = 0;
            return;
        end
        ev[0] = 1;
        for (int i = 0; i < NS; i++) begin
            ev[1 + i]      = stall[i];
            ev[1 + NS + i] = clear[i];
        end
        for (int p = 0; p < NP; p++) ev[1 + 2 * NS + p] = (mem_read[p] | mem_write[p]) & mem_resp[p];
        if (!m_halt[c]) begin
            for (int k = 0; k < NCNT; k++)
                if (ev[k] && old[k] < c_max[c]) m_cnt[c][k] = old[k] + 1;
        end
        is_halt_instr = id_valid && (id_ir == 32'h63 || id_ir == 32'h6F);
        if (is_halt_instr) begin
            m_run[c]++;
            if (m_run[c] == c_hc[c]) m_halt[c] = 1;
        end else begin
            m_run[c] = 0;
        end
        first = -1;
        for (int p = 0; p < NP; p++) begin
            if ((mem_read[p] | mem_write[p]) & ~mem_resp[p]) begin
                m_age[c][p]++;
                if (m_age[c][p] == c_to[c] - 1 && first < 0) first = p;
            end else begin
                m_age[c][p] = 0;
            end
        end
        if (!m_tmo[c] && first >= 0) begin
            m_tmo[c]   = 1;
            m_tport[c] = first;
        end
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check("a_rd_data", a_rd, m_rd[0]);
        check("a_halt", a_halt, m_halt[0]);
        check("a_timeout", a_tmo, m_tmo[0]);
        if (m_tmo[0]) check("a_timeout_port", a_tport, m_tport[0]);
        check("b_rd_data", b_rd, m_rd[1]);
        check("b_halt", b_halt, m_halt[1]);
        check("b_timeout", b_tmo, m_tmo[1]);
        if (m_tmo[1]) check("b_timeout_port", b_tport, m_tport[1]);
    endtask

    task automatic idle_inputs();
        stall = '0; clear = '0; id_ir = '0; id_valid = 1'b0;
        mem_read = '0; mem_write = '0; mem_resp = '0; cnt_clr = 1'b0;
    endtask

    task automatic do_clr();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    int n;
    logic [NP-1:0] req;
    logic [NP-1:0] is_wr;
    int hot;

    initial begin
        idle_inputs();
        rd_sel = '0;
        rst_n  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Cycle count after reset: 11 edges, one-cycle readout latency.
        for (int i = 0; i < 11; i++) tick();
        check("cycle_after_reset", a_rd, 10);
        for (int s = 1; s < 32; s++) begin
            rd_sel = 5'(s);
            tick();
        end

        // Stall and clear per-stage counting.
        do_clr();
        stall = 5'b00100;
        repeat (7) tick();
        stall = '0;
        clear = 5'b00010;
        repeat (3) tick();
        clear = '0;
        rd_sel = 5'd3;
        tick();
        check("stall2_count", a_rd, 7);
        rd_sel = 5'd7;
        tick();
        check("clear1_count", a_rd, 3);

        // D-side reads completing on their 4th cycle.
        do_clr();
        for (int t = 0; t < 5; t++) begin
            mem_read = 2'b10;
            repeat (3) tick();
            mem_resp = 2'b10;
            tick();
            mem_read = '0;
            mem_resp = '0;
            tick();
        end
        rd_sel = 5'd12;
        tick();
        check("dside_trans", a_rd, 5);
        check("no_timeout_1024", a_tmo, 0);

        // Watchdog latency on port 0, later port 1 firing must not move the port.
        do_clr();
        mem_write = 2'b01;
        n = 0;
        while (b_tmo == 1'b0 && n < 20) begin
            tick();
            n++;
        end
        check("timeout_latency", n, 7);
        check("timeout_port0", b_tport, 0);
        mem_read = 2'b10;
        repeat (10) tick();
        check("timeout_port_sticky", b_tport, 0);
        idle_inputs();
        do_clr();
        mem_read = 2'b10;
        repeat (8) tick();
        check("timeout_port1_only", b_tport, 1);
        idle_inputs();
        do_clr();
        mem_read = 2'b11;
        repeat (8) tick();
        check("timeout_simul_lowest", b_tport, 0);
        idle_inputs();
        do_clr();

        // Halt idiom: short run, bubble, full run, then frozen counters.
        id_ir = 32'h0000_0063;
        id_valid = 1'b1;
        repeat (3) tick();
        check("halt_short_run", a_halt, 0);
        id_valid = 1'b0;
        tick();
        id_valid = 1'b1;
        repeat (3) tick();
        check("halt_before_4th", a_halt, 0);
        tick();
        check("halt_after_4th", a_halt, 1);
        id_valid = 1'b0;
        rd_sel = 5'd1;
        for (int i = 0; i < 6; i++) begin
            stall = 5'(i);
            tick();
        end
        stall = '0;
        idle_inputs();

        // Saturation of a 4-bit counter, then clear winning over a same-cycle stall.
        do_clr();
        stall = 5'b00001;
        repeat (20) tick();
        rd_sel = 5'd1;
        tick();
        check("sat_4bit", b_rd, 15);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        stall = '0;
        tick();
        check("clr_beats_stall", b_rd, 0);

        // Randomized traffic against the model.
        idle_inputs();
        req = '0;
        is_wr = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            hot = ((cyc / 150) % 3 == 0) ? 30 : 2;
            rst_n   = ($urandom_range(0, 299) != 0);
            cnt_clr = ($urandom_range(0, 39) == 0);
            stall   = NS'($urandom);
            clear   = NS'($urandom) & NS'($urandom);
            id_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < hot)
                id_ir = $urandom_range(0, 1) ? 32'h63 : 32'h6F;
            else
                id_ir = $urandom;
            for (int p = 0; p < NP; p++) begin
                if (req[p]) begin
                    if ($urandom_range(0, 7) == 0) req[p] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req[p]   = 1'b1;
                    is_wr[p] = 1'($urandom);
                end
                mem_read[p]  = req[p] & ~is_wr[p];
                mem_write[p] = req[p] & is_wr[p];
                mem_resp[p]  = ($urandom_range(0, 9) == 0);
                if (mem_resp[p] && req[p] && $urandom_range(0, 1) == 0) req[p] = 1'b0;
            end
            rd_sel = 5'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/pipeline_event_monitor.md
Name: pipeline_event_monitor

Overview:
- Synthesizable in-design monitor for the mp3 pipelined RISC-V core.
- Counts per-stage stall and clear events and per-port memory transactions.
- Detects the branch-to-self halt idiom and flags memory requests that wait too long for a response.
- Exposes all counters through a registered select/readout port, so the monitoring done in simulation also works in hardware.

Parameters:
- NUM_STAGES, 5, number of pipeline register stages providing stall/clear strobes.
- NUM_PORTS, 2, number of memory request ports monitored (port 0 = I-side, port 1 = D-side).
- CNT_WIDTH, 32, width of every event counter.
- HALT_CYCLES, 4, consecutive cycles a halt instruction must sit in ID before halt asserts; legal range 1..255.
- TIMEOUT, 1024, cycles a request may stay outstanding before timeout fires; legal range 2..65535.
- SEL_WIDTH, 5, width of counter select; must satisfy 2^SEL_WIDTH >= 1+2*NUM_STAGES+NUM_PORTS.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- stall  in  NUM_STAGES  per-stage stall strobe, bit i = pipeline register i.
- clear  in  NUM_STAGES  per-stage clear/flush strobe.
- id_ir  in  32  instruction currently in ID.
- id_valid  in  1  id_ir holds a real instruction (not a bubble).
- mem_read  in  NUM_PORTS  per-port read request.
- mem_write  in  NUM_PORTS  per-port write request.
- mem_resp  in  NUM_PORTS  per-port response strobe.
- cnt_clr  in  1  synchronous clear of all counters, halt and timeout state.
- rd_sel  in  SEL_WIDTH  counter index for readout.
- rd_data  out  CNT_WIDTH  registered value of the selected counter.
- halt  out  1  sticky halt detected.
- timeout  out  1  sticky watchdog fired.
- timeout_port  out  $clog2(NUM_PORTS) (min 1)  port that fired first.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - All counters, halt, timeout, timeout_port, rd_data, halt run-length and watchdog counters go to 0 on that edge.
  - Reset mid-transaction discards all in-flight tracking.
- cnt_clr=1:
  - Same effect as reset except rd_data, which samples the cleared values next cycle.
  - cnt_clr has priority over any same-cycle increment.
- Counter map (index: meaning):
  - 0: cycle count.
  - 1..NUM_STAGES: stall[i-1] cycles.
  - NUM_STAGES+1..2*NUM_STAGES: clear[i-NUM_STAGES-1] cycles.
  - 2*NUM_STAGES+1..2*NUM_STAGES+NUM_PORTS: completed transactions, i.e. cycles with (read|write)&resp.
  - Indices past the map read 0.
- Counters saturate at all-ones and never wrap.
- Freeze: once halt=1, every event counter holds its value; watchdogs and readout keep running.
- Readout: rd_data <= counter[rd_sel] each cycle, 1-cycle latency, showing the pre-increment value from the cycle rd_sel was sampled.
- Halt detection:
  - Match = id_valid & (id_ir==32'h00000063 | id_ir==32'h0000006F).
  - A run counter increments on match and returns to 0 on any non-match.
  - halt sets on the edge where the run count reaches HALT_CYCLES; it is sticky until reset/cnt_clr.
  - HALT_CYCLES=1 means halt rises the cycle after the first match.
- Watchdog, per port:
  - Counter increments while (read|write)&~resp.
  - It returns to 0 on resp or when the request drops.
  - When it reaches TIMEOUT-1 while still outstanding, timeout sets and timeout_port latches that port index.
  - Simultaneous firing: lowest index wins.
  - Further firings do not change timeout_port until cleared.
- Request and resp in the same cycle counts one transaction and does not advance the watchdog.

Test Plan:
- Reset, then 10 idle cycles, rd_sel=0 -> rd_data=9 or 10 per 1-cycle latency (bench checks exact 10 after 11 edges); all other indices 0; halt=0, timeout=0.
- stall=5'b00100 for 7 cycles, clear=5'b00010 for 3 cycles -> counter 3 = 7, counter 7 = 3, others 0.
- mem_read[1]=1 with resp on the 4th cycle, repeated 5 times -> counter 12 = 5; no timeout with TIMEOUT=1024.
- TIMEOUT=8, mem_write[0] held with no resp -> timeout=1 exactly 7 cycles after request rises, timeout_port=0; port 1 firing later leaves timeout_port=0.
- id_ir=32'h00000063, id_valid=1 for 3 cycles, then one bubble, then 4 cycles -> halt=0 after the first run, halt=1 after the 4th cycle of the second run; further stall pulses leave counters frozen.
- Counter driven with CNT_WIDTH=4 and stall held 20 cycles -> counter = 4'hF (saturated); cnt_clr asserted together with a stall -> counter = 0.
